// File: rtl/pc_sequencer.sv
// pc_sequencer
// Run-control sequencer for the pico MIPS program counter and register-file
// write path. Each cycle it decides whether the PC advances, takes a relative
// branch or holds. Multi-cycle instructions are stretched with a stall
// counter. Execution stops on a HALT opcode, an external halt request or an
// address breakpoint.
//
// Ports
//   clk_i            : single clock, all state updates on the rising edge
//   reset_i          : synchronous active-high reset
//   run_i / step_i   : start continuous / single-instruction execution from IDLE
//   halt_req_i       : level request to stop at the next instruction boundary
//   addr_i           : current PC value
//   is_branch_i      : decoded instruction is a conditional relative branch
//   branch_cond_i    : branch condition flag for the current instruction
//   is_multi_i       : decoded instruction is multi-cycle
//   is_halt_i        : decoded instruction is HALT
//   bp_en_i          : breakpoint enable
//   bp_addr_i        : breakpoint address
//   pc_halt_o        : hold the PC this cycle
//   pc_rel_branch_o  : PC takes its relative offset this cycle
//   reg_we_o         : register-file write enable for the retiring instruction
//   retire_o         : one-cycle pulse per retired instruction
//   bp_hit_o         : one-cycle pulse when a breakpoint stops execution
//   halted_o         : core stopped by a HALT opcode
//   busy_o           : sequencer is in RUN or STALL
//   retired_cnt_o    : retired-instruction count, wraps modulo 2^CntSz
module pc_sequencer #(
   parameter int AddrSz    = 6,
   parameter int MulCycles = 4,
   parameter int CntSz     = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              run_i,
   input  logic              step_i,
   input  logic              halt_req_i,
   input  logic [AddrSz-1:0] addr_i,
   input  logic              is_branch_i,
   input  logic              branch_cond_i,
   input  logic              is_multi_i,
   input  logic              is_halt_i,
   input  logic              bp_en_i,
   input  logic [AddrSz-1:0] bp_addr_i,
   output logic              pc_halt_o,
   output logic              pc_rel_branch_o,
   output logic              reg_we_o,
   output logic              retire_o,
   output logic              bp_hit_o,
   output logic              halted_o,
   output logic              busy_o,
   output logic [CntSz-1:0]  retired_cnt_o
);

   localparam int StallW = $clog2(MulCycles);
   // The RUN cycle is the first of the multi-cycle instruction and the
   // counter reaching zero marks the last, hence the load of MulCycles-2.
   localparam logic [StallW-1:0] StallLoad = StallW'(MulCycles - 2);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STALL,
      HALTED
   } state_e;

   state_e             state_q, state_d;
   logic               stepMode_q, stepMode_d;
   logic               bpSkip_q, bpSkip_d;
   logic [StallW-1:0]  stallCnt_q, stallCnt_d;
   logic [CntSz-1:0]   retiredCnt_q, retiredCnt_d;
   logic               bpMatch;

   assign bpMatch = bp_en_i && (addr_i == bp_addr_i) && !bpSkip_q;

   // State register and the retired-instruction counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         stepMode_q   <= 1'b0;
         bpSkip_q     <= 1'b0;
         stallCnt_q   <= '0;
         retiredCnt_q <= '0;
      end else begin
         state_q      <= state_d;
         stepMode_q   <= stepMode_d;
         bpSkip_q     <= bpSkip_d;
         stallCnt_q   <= stallCnt_d;
         retiredCnt_q <= retiredCnt_d;
      end
   end

   // Next-state and strobe decode. Strobes are combinational so they act on
   // the same edge the PC updates. While reset is asserted the strobes are
   // forced to their idle values so a reset landing on a final STALL cycle
   // cannot produce a partial retire.
   always_comb begin
      state_d         = state_q;
      stepMode_d      = stepMode_q;
      bpSkip_d        = bpSkip_q;
      stallCnt_d      = stallCnt_q;
      pc_halt_o       = 1'b1;
      pc_rel_branch_o = 1'b0;
      reg_we_o        = 1'b0;
      retire_o        = 1'b0;
      bp_hit_o        = 1'b0;

      case (state_q)
         IDLE: begin
            if (run_i) begin
               state_d    = RUN;
               stepMode_d = 1'b0;
            end else if (step_i) begin
               state_d    = RUN;
               stepMode_d = 1'b1;
            end
         end
         RUN: begin
            if (is_halt_i) begin
               state_d = HALTED;
            end else if (halt_req_i) begin
               state_d = IDLE;
            end else if (bpMatch) begin
               bp_hit_o = 1'b1;
               bpSkip_d = 1'b1;
               state_d  = IDLE;
            end else if (is_multi_i) begin
               stallCnt_d = StallLoad;
               state_d    = STALL;
            end else begin
               pc_halt_o       = 1'b0;
               retire_o        = 1'b1;
               pc_rel_branch_o = is_branch_i & branch_cond_i;
               reg_we_o        = !is_branch_i;
               bpSkip_d        = 1'b0;
               state_d         = stepMode_q ? IDLE : RUN;
            end
         end
         STALL: begin
            if (stallCnt_q == '0) begin
               pc_halt_o = 1'b0;
               reg_we_o  = 1'b1;
               retire_o  = 1'b1;
               bpSkip_d  = 1'b0;
               state_d   = stepMode_q ? IDLE : RUN;
            end else begin
               stallCnt_d = stallCnt_q - 1'b1;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (reset_i) begin
         pc_halt_o       = 1'b1;
         pc_rel_branch_o = 1'b0;
         reg_we_o        = 1'b0;
         retire_o        = 1'b0;
         bp_hit_o        = 1'b0;
      end

      retiredCnt_d = retiredCnt_q + {{(CntSz-1){1'b0}}, retire_o};
   end

   assign halted_o      = (state_q == HALTED);
   assign busy_o        = (state_q == RUN) || (state_q == STALL);
   assign retired_cnt_o = retiredCnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Run-control sequencer for the program counter and register-file write path of the pico MIPS core. Each cycle it decides whether the PC advances, branches relative or holds. It stretches multi-cycle instructions with a stall counter and stops execution on a HALT opcode, an external halt request or an address breakpoint. Sits between the instruction decoder/ALU flags and the `pc` block; `pc_halt`/`pc_rel_branch` connect directly to the PC's `halt`/`rel_branch`.

## Interface

- `AddrSz`, 6: PC / instruction address width.
- `MulCycles`, 4: total cycles occupied by a multi-cycle instruction; legal range 2..16.
- `CntSz`, 16: width of the retired-instruction counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start continuous execution from IDLE.
- `step` in 1: execute exactly one instruction from IDLE.
- `halt_req` in 1: level request to stop at the next instruction boundary.
- `addr` in AddrSz: current PC value.
- `is_branch` in 1: decoded instruction is a conditional relative branch.
- `branch_cond` in 1: branch condition flag for the current instruction.
- `is_multi` in 1: decoded instruction is multi-cycle.
- `is_halt` in 1: decoded instruction is HALT.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in AddrSz: breakpoint address.
- `pc_halt` out 1: hold PC this cycle.
- `pc_rel_branch` out 1: PC takes relative offset this cycle.
- `reg_we` out 1: register-file write enable for the retiring instruction.
- `retire` out 1: one-cycle pulse per retired instruction.
- `bp_hit` out 1: one-cycle pulse when a breakpoint stops execution.
- `halted` out 1: core halted by HALT opcode.
- `busy` out 1: state is RUN or STALL.
- `retired_cnt` out CntSz: retired-instruction count; wraps modulo 2^CntSz.

## Operation

- States: IDLE, RUN, STALL, HALTED. Registered state; `pc_halt`, `pc_rel_branch`, `reg_we`, `retire` and `bp_hit` are combinational from the state and the current-cycle decode inputs, so they act on the same edge the PC updates.
- Internal registers: `step_mode`, `bp_skip`, stall counter of width $clog2(MulCycles).
- IDLE: `pc_halt`=1, all other strobes 0.
  - `run` -> RUN with `step_mode`=0.
  - Else `step` -> RUN with `step_mode`=1.
  - `run` takes priority over `step` when both are asserted.
- RUN decisions, highest priority first:
  1. `is_halt`: `pc_halt`=1, no write, no retire -> HALTED.
  2. `halt_req`: `pc_halt`=1, nothing retires -> IDLE.
  3. Breakpoint, when `bp_en` && `addr`==`bp_addr` && !`bp_skip`: `pc_halt`=1, `bp_hit`=1, set `bp_skip` -> IDLE.
  4. `is_multi`: `pc_halt`=1, counter loads MulCycles-2 -> STALL.
  5. Otherwise the instruction retires:
     - `pc_halt`=0, `retire`=1.
     - `pc_rel_branch` = `is_branch`&`branch_cond`.
     - `reg_we` = !`is_branch`.
     - Clear `bp_skip`; go to IDLE if `step_mode`, else stay in RUN.
- STALL: `pc_halt`=1 and the counter decrements each cycle. When the counter is 0, the multi-cycle instruction retires: `pc_halt`=0, `reg_we`=1, `pc_rel_branch`=0, `retire`=1, clear `bp_skip`. Next state is IDLE if `step_mode`, else RUN. `halt_req` is ignored in STALL, so an in-flight instruction always completes.
- HALTED: `pc_halt`=1, `halted`=1. Only `reset` exits.
- `retired_cnt` increments on every cycle where `retire`=1.

## Timing

- Reset values: state IDLE, `pc_halt`=1, `pc_rel_branch`=0, `reg_we`=0, `retire`=0, `bp_hit`=0, `halted`=0, `busy`=0, `retired_cnt`=0, `step_mode`=0, `bp_skip`=0, counter 0.
- `reset` asserted in any state, including mid-STALL, returns to IDLE on that edge. No partial retire occurs.
- Start latency: `run` sampled in IDLE at edge N; the first instruction can retire in the cycle after edge N.
- Single-cycle instructions: 1 cycle each; the PC advances on the edge that ends the cycle.
- Multi-cycle instructions: exactly MulCycles cycles (1 RUN + MulCycles-1 STALL); retire in the last cycle.
- Resuming after a breakpoint: `bp_skip` lets the instruction at `bp_addr` execute once. The breakpoint re-arms after that instruction retires.

## Test plan

- Reset, then `run`, with five single-cycle non-branch instructions -> `retire` high for 5 consecutive cycles, `retired_cnt`=5, `reg_we`=1 each cycle, `pc_halt`=0.
- Branch at `addr`=3 with `branch_cond`=1 -> `pc_rel_branch`=1, `reg_we`=0 that cycle. Same branch with `branch_cond`=0 -> `pc_rel_branch`=0, `retire`=1.
- `is_multi` with MulCycles=4 -> `pc_halt`=1 for 3 cycles, then `reg_we`=1, `retire`=1 in cycle 4. Assert `halt_req` during the stall -> the instruction still retires, then IDLE.
- `bp_en`=1, `bp_addr`=5, running from 0 -> `bp_hit` pulses at `addr`=5, state IDLE, `retired_cnt`=5. Then `step` -> the instruction at 5 retires once, back to IDLE, `bp_hit` stays 0.
- `is_halt` at `addr`=2 -> `halted`=1, `pc_halt`=1 permanently, and `run` is ignored. `reset` -> `halted`=0, state IDLE.
- `reset` pulsed during STALL cycle 2 -> `retire` never pulses for that instruction, all outputs return to their reset values on the next cycle.
